// File: rtl/uvmt_cv32e40x_sl_fifo_pkg.sv
// ---------------------------------------------------------------------------
// Package uvmt_cv32e40x_sl_fifo_pkg
// Purpose : Shared types and helpers for the multi-channel support-logic FIFO
//           (uvmt_cv32e40x_sl_fifo_mc).
//           - sl_fifo_item_t : default packed item type. It has the field
//             layout of the core's instruction-side OBI request, so this
//             slice builds without the core package.
//           - sl_fifo_op_e   : per-channel operation decoded from add/shift.
//           - sl_fifo_cnt_w  : width of an occupancy counter for a given depth.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package uvmt_cv32e40x_sl_fifo_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } sl_fifo_item_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSHPOP
  } sl_fifo_op_e;

  // The counter has to represent 0..depth inclusive, hence depth+1 values.
  function automatic int unsigned sl_fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_sl_fifo_mc_if.sv
// ---------------------------------------------------------------------------
// Interface uvmt_cv32e40x_sl_fifo_mc_if
// Purpose : Bundles the per-channel request and status signals of
//           uvmt_cv32e40x_sl_fifo_mc. Each vector is indexed by channel.
// Ports   : none. Modports:
//           master : drives add_item, shift_fifo, item_in, err_clr and
//                    observes all status/data outputs
//           slave  : the FIFO side (the opposite directions)
// Signals :
//   add_item/shift_fifo [NUM_CH]   push / pop request per channel
//   item_in   [NUM_CH] x item      push data
//   err_clr                        clears every sticky error bit
//   item_out  [NUM_CH] x item      oldest item, '0 when the channel is empty
//   item_valid/full [NUM_CH]       non-empty / count == FIFO_DEPTH
//   count     [NUM_CH] x CNT_W     occupancy
//   item_peek/peek_valid           second-oldest item and its valid flag
//   overflow_err/underflow_err     sticky error flags
// ---------------------------------------------------------------------------
interface uvmt_cv32e40x_sl_fifo_mc_if
  import uvmt_cv32e40x_sl_fifo_pkg::*;
#(
  parameter type         FIFO_TYPE_T = sl_fifo_item_t,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned NUM_CH      = 1
);

  localparam int unsigned CNT_W = sl_fifo_cnt_w(FIFO_DEPTH);

  logic       [NUM_CH-1:0]            add_item;
  logic       [NUM_CH-1:0]            shift_fifo;
  FIFO_TYPE_T [NUM_CH-1:0]            item_in;
  logic                               err_clr;
  FIFO_TYPE_T [NUM_CH-1:0]            item_out;
  logic       [NUM_CH-1:0]            item_valid;
  logic       [NUM_CH-1:0]            full;
  logic       [NUM_CH-1:0][CNT_W-1:0] count;
  FIFO_TYPE_T [NUM_CH-1:0]            item_peek;
  logic       [NUM_CH-1:0]            peek_valid;
  logic       [NUM_CH-1:0]            overflow_err;
  logic       [NUM_CH-1:0]            underflow_err;

  modport master (
    output add_item, shift_fifo, item_in, err_clr,
    input  item_out, item_valid, full, count, item_peek, peek_valid,
           overflow_err, underflow_err
  );

  modport slave (
    input  add_item, shift_fifo, item_in, err_clr,
    output item_out, item_valid, full, count, item_peek, peek_valid,
           overflow_err, underflow_err
  );

endinterface

// File: rtl/uvmt_cv32e40x_sl_fifo_ch.sv
// ---------------------------------------------------------------------------
// Module uvmt_cv32e40x_sl_fifo_ch
// Purpose : One channel of the support-logic FIFO: a circular buffer of
//           FIFO_DEPTH entries that always presents its oldest item, with
//           occupancy, full/empty status and sticky overflow/underflow flags.
// Config  : UVMT_CV32E40X_SL_FIFO_PEEK_EN -- when defined, item_peek shows
//           the second-oldest entry; otherwise item_peek/peek_valid are tied 0.
// Ports   :
//   clk_i, rst_i           clock, synchronous active-high reset
//   add_item, shift_fifo   push / pop request
//   item_in                push data
//   err_clr                clears the sticky error flags
//   item_out, item_valid   oldest entry ('0 when empty) and non-empty flag
//   full, count            occupancy status
//   item_peek, peek_valid  second-oldest entry and count >= 2
//   overflow_err           sticky: push into a full channel without a pop
//   underflow_err          sticky: pop from an empty channel
// ---------------------------------------------------------------------------
module uvmt_cv32e40x_sl_fifo_ch
  import uvmt_cv32e40x_sl_fifo_pkg::*;
#(
  parameter type         FIFO_TYPE_T = sl_fifo_item_t,
  parameter int unsigned FIFO_DEPTH  = 2,
  localparam int unsigned CNT_W      = sl_fifo_cnt_w(FIFO_DEPTH),
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             add_item,
  input  logic             shift_fifo,
  input  FIFO_TYPE_T       item_in,
  input  logic             err_clr,
  output FIFO_TYPE_T       item_out,
  output logic             item_valid,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output FIFO_TYPE_T       item_peek,
  output logic             peek_valid,
  output logic             overflow_err,
  output logic             underflow_err
);

  FIFO_TYPE_T       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             unf_q;
  logic             is_empty;
  logic             is_full;
  sl_fifo_op_e      op;

  // Pointers wrap by explicit compare so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_W'(FIFO_DEPTH));

  // Decode the request pair into a single operation so the update logic
  // below reads as one case per situation.
  always_comb begin
    op = OP_IDLE;
    case ({add_item, shift_fifo})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_PUSHPOP;
      default: op = OP_IDLE;
    endcase
  end

  // Storage, pointers, count and sticky flags. err_clr is applied first so
  // that an error event in the same cycle, assigned later, wins. A push+pop
  // on a full channel writes into the slot being vacated, which is exactly
  // rd_ptr == wr_ptr, so no special case is needed there. A push+pop on an
  // empty channel keeps the push and flags the pop as an underflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (op)
        OP_PUSH: begin
          if (!is_full) begin
            mem[wr_ptr] <= item_in;
            wr_ptr      <= ptr_inc(wr_ptr);
            cnt         <= cnt + CNT_W'(1);
          end else begin
            ovf_q <= 1'b1;
          end
        end
        OP_POP: begin
          if (!is_empty) begin
            rd_ptr <= ptr_inc(rd_ptr);
            cnt    <= cnt - CNT_W'(1);
          end else begin
            unf_q <= 1'b1;
          end
        end
        OP_PUSHPOP: begin
          mem[wr_ptr] <= item_in;
          wr_ptr      <= ptr_inc(wr_ptr);
          if (!is_empty) begin
            rd_ptr <= ptr_inc(rd_ptr);
          end else begin
            cnt   <= cnt + CNT_W'(1);
            unf_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count         = cnt;
  assign item_valid    = !is_empty;
  assign full          = is_full;
  assign item_out      = is_empty ? FIFO_TYPE_T'('0) : mem[rd_ptr];
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef UVMT_CV32E40X_SL_FIFO_PEEK_EN
  // count > 1 rather than >= 2 so a 1-bit counter (depth 1) stays legal.
  assign peek_valid = (cnt > CNT_W'(1));
  assign item_peek  = peek_valid ? mem[ptr_inc(rd_ptr)] : FIFO_TYPE_T'('0);
`else
  assign peek_valid = 1'b0;
  assign item_peek  = FIFO_TYPE_T'('0);
`endif

endmodule

// File: rtl/uvmt_cv32e40x_sl_fifo_mc.sv
// ---------------------------------------------------------------------------
// Module uvmt_cv32e40x_sl_fifo_mc
// Purpose : Multi-channel, depth-parametrised support-logic FIFO, e.g. one
//           channel per OBI interface holding outstanding requests until
//           their responses arrive. Channels are fully independent.
// Config  : UVMT_CV32E40X_SL_FIFO_PEEK_EN enables the second-oldest item
//           view (item_peek/peek_valid); without it those outputs are 0.
// Params  : FIFO_TYPE_T (packed item type), FIFO_DEPTH >= 1, NUM_CH >= 1
// Ports   :
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   fifo_bus  uvmt_cv32e40x_sl_fifo_mc_if.slave -- per-channel push/pop
//             requests, data, err_clr, and all status/data outputs
// ---------------------------------------------------------------------------
module uvmt_cv32e40x_sl_fifo_mc
  import uvmt_cv32e40x_sl_fifo_pkg::*;
#(
  parameter type         FIFO_TYPE_T = sl_fifo_item_t,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned NUM_CH      = 1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  uvmt_cv32e40x_sl_fifo_mc_if.slave fifo_bus
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    uvmt_cv32e40x_sl_fifo_ch #(
      .FIFO_TYPE_T (FIFO_TYPE_T),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .add_item      (fifo_bus.add_item[c]),
      .shift_fifo    (fifo_bus.shift_fifo[c]),
      .item_in       (fifo_bus.item_in[c]),
      .err_clr       (fifo_bus.err_clr),
      .item_out      (fifo_bus.item_out[c]),
      .item_valid    (fifo_bus.item_valid[c]),
      .full          (fifo_bus.full[c]),
      .count         (fifo_bus.count[c]),
      .item_peek     (fifo_bus.item_peek[c]),
      .peek_valid    (fifo_bus.peek_valid[c]),
      .overflow_err  (fifo_bus.overflow_err[c]),
      .underflow_err (fifo_bus.underflow_err[c])
    );
  end

endmodule
